dmem_bank: RTL and testbench

- Parametrised successor of the single-port data memory: word-addressed RAM with byte/half/word access, sign/zero extension and a valid/ready request/response handshake.
- Configurable read latency; one outstanding access.
- Sits between the MEM-stage load/store unit and the backing RAM array; the stage stalls on req_ready/rsp_valid.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_bank_if.sv | 34 +++
 rtl/dmem_lane_ext.sv | 40 ++++
 rtl/dmem_bank.sv | 141 ++++++++++++++
 tb/tb_dmem_bank.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and helpers for the dmem_bank data memory.
// Holds the access-size codes, the FSM state type and the byte-enable and
// alignment helpers used by the bank and its lane extender.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte lanes touched by an access. Half ignores addr[0], word and the
    // illegal size 3 cover the whole word.
    function automatic logic [3:0] byte_en(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << addr_lo;
            SZ_HALF: byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    // True for a half on an odd address, a word off a word boundary, or size 3.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_lo[0];
            SZ_WORD: misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank_if.sv
// dmem_bank_if: request/response bus between the load/store unit and dmem_bank.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both high. Once raised, valid and its payload
// stay stable until the transfer edge. req_ready never looks at req_valid.
interface dmem_bank_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_ext.sv
// dmem_lane_ext: picks the addressed byte/half/word out of a read word and
// sign- or zero-extends it to XLEN. Purely combinational.
module dmem_lane_ext
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_word,
    input  logic [1:0]      i_addr_lo,
    input  logic [1:0]      i_size,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select: byte by addr[1:0], half by addr[1] only.
    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    // Extension; size 3 falls through to a full word.
    always_comb begin
        o_data = i_word;
        case (i_size)
            SZ_BYTE: o_data = {{(XLEN-8){~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{(XLEN-16){~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_bank.sv
// dmem_bank: word-addressed data RAM with byte/half/word access, a
// valid/ready request/response bus and a configurable read latency.
// One access is outstanding at a time. Define DMEM_MISALIGN_CHK_EN to flag
// misaligned or size-3 accesses on rsp_err instead of silently aligning them.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    dmem_bank_if.slave   bus,
    output state_t       o_dbg_state
);

    localparam int         IDX_W  = $clog2(DEPTH);
    localparam logic [1:0] LAT_M1 = 2'(LATENCY - 1);

    logic [XLEN-1:0] r_mem [DEPTH];

    state_t          r_state;
    logic [1:0]      r_cnt;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;

    logic             w_accept;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_lo;
    logic             w_err;
    logic [3:0]       w_be;
    logic [XLEN-1:0]  w_wdata_al;
    logic [XLEN-1:0]  w_rd_word;
    logic [XLEN-1:0]  w_ext;
    logic             w_unused_addr;

    // Upper address bits are don't-care: the index wraps modulo DEPTH.
    assign w_unused_addr = ^bus.req_addr[ADDR_W-1:IDX_W+2];

    assign w_accept = (r_state == IDLE) && bus.req_valid;
    assign w_idx    = bus.req_addr[IDX_W+1:2];
    assign w_lo     = bus.req_addr[1:0];

`ifdef DMEM_MISALIGN_CHK_EN
    assign w_err = misaligned(bus.req_size, w_lo);
`else
    assign w_err = 1'b0;
`endif

    // A flagged access must leave memory untouched, so it gets no lanes.
    assign w_be      = w_err ? 4'b0000 : byte_en(bus.req_size, w_lo);
    assign w_rd_word = r_mem[w_idx];

    // Replicate store data so each enabled lane sees its own bytes.
    always_comb begin
        w_wdata_al = bus.req_wdata;
        case (bus.req_size)
            SZ_BYTE: w_wdata_al = {4{bus.req_wdata[7:0]}};
            SZ_HALF: w_wdata_al = {2{bus.req_wdata[15:0]}};
            default: w_wdata_al = bus.req_wdata;
        endcase
    end

    dmem_lane_ext #(.XLEN(XLEN)) u_lane_ext (
        .i_word     (w_rd_word),
        .i_addr_lo  (w_lo),
        .i_size     (bus.req_size),
        .i_unsigned (bus.req_unsigned),
        .o_data     (w_ext)
    );

    // RAM write at the acceptance edge; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_al[8*b +: 8];
                end
            end
        end
    end

    // Access FSM: accept in IDLE, count latency in WAIT, hold response in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 2'd0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rdata <= (bus.req_we || w_err) ? '0 : w_ext;
                        r_err   <= w_err;
                        if (LATENCY == 1) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_cnt       <= 2'd0;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    // Leaving as the counter steps to zero keeps the total
                    // acceptance-to-sample distance at exactly LATENCY edges.
                    if (r_cnt <= 2'd1) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_cnt       <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dmem_bank.sv
// tb_dmem_bank: drives two dmem_bank instances (LATENCY 1 and 3) through a
// shared driver, one at a time, with an expected-response queue.
module tb_dmem_bank;
  import dmem_pkg::*;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  dmem_bank_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus1 ();
  dmem_bank_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus3 ();
  state_t dbg1, dbg3;

  dmem_bank #(.XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .o_dbg_state(dbg1)
  );
  dmem_bank #(.XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .o_dbg_state(dbg3)
  );

  // shared stimulus, steered by sel (0 -> LATENCY 1, 1 -> LATENCY 3)
  logic              sel;
  logic              t_valid, t_we, t_uns, t_rready;
  logic [1:0]        t_size;
  logic [ADDR_W-1:0] t_addr;
  logic [XLEN-1:0]   t_wdata;
  int                exp_lat;

  assign bus1.req_valid    = t_valid & ~sel;
  assign bus3.req_valid    = t_valid & sel;
  assign bus1.rsp_ready    = t_rready & ~sel;
  assign bus3.rsp_ready    = t_rready & sel;
  assign bus1.req_we       = t_we;
  assign bus3.req_we       = t_we;
  assign bus1.req_size     = t_size;
  assign bus3.req_size     = t_size;
  assign bus1.req_unsigned = t_uns;
  assign bus3.req_unsigned = t_uns;
  assign bus1.req_addr     = t_addr;
  assign bus3.req_addr     = t_addr;
  assign bus1.req_wdata    = t_wdata;
  assign bus3.req_wdata    = t_wdata;

  logic            w_req_ready, w_rsp_valid, w_rsp_err;
  logic [XLEN-1:0] w_rsp_rdata;
  state_t          w_dbg;
  assign w_req_ready = sel ? bus3.req_ready : bus1.req_ready;
  assign w_rsp_valid = sel ? bus3.rsp_valid : bus1.rsp_valid;
  assign w_rsp_err   = sel ? bus3.rsp_err   : bus1.rsp_err;
  assign w_rsp_rdata = sel ? bus3.rsp_rdata : bus1.rsp_rdata;
  assign w_dbg       = sel ? dbg3 : dbg1;

  // ---------------- scoreboard ----------------
  logic [XLEN:0] exp_q[$];   // {err, rdata}
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [XLEN:0] act, input logic [XLEN:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (lat%0d)", tag, act, exp, exp_lat);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [ADDR_W-1:0] addr, input logic [XLEN-1:0] wdata);
    int n;
    @(negedge clk);
    t_valid = 1'b1; t_we = we; t_size = size; t_uns = uns; t_addr = addr; t_wdata = wdata;
    n = 0;
    while (!w_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", {32'd0, w_req_ready}, 33'd1);
    @(posedge clk);
    #1 t_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input int hold);
    int lat;
    logic [XLEN:0] exp, held;
    t_rready = (hold == 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!w_rsp_valid && lat < 20);
    check({tag, "_valid"}, {32'd0, w_rsp_valid}, 33'd1);
    check({tag, "_lat"}, 33'(lat), 33'(exp_lat));
    if (hold > 0) begin
      held = {w_rsp_err, w_rsp_rdata};
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_v"}, {32'd0, w_rsp_valid}, 33'd1);
        check({tag, "_hold_d"}, {w_rsp_err, w_rsp_rdata}, held);
        check({tag, "_hold_rdy"}, {32'd0, w_req_ready}, 33'd0);
      end
      t_rready = 1'b1;
    end
    check({tag, "_sb_depth"}, 33'(exp_q.size()), 33'd1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({tag, "_data"}, {w_rsp_err, w_rsp_rdata}, exp);
    end
    @(negedge clk);
    check({tag, "_done"}, {32'd0, w_rsp_valid}, 33'd0);
    check({tag, "_rdy_back"}, {32'd0, w_req_ready}, 33'd1);
    t_rready = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [ADDR_W-1:0] addr, input logic [XLEN-1:0] wdata,
                        input logic [XLEN-1:0] exp_data, input logic exp_err, input int hold);
    exp_q.push_back({exp_err, exp_data});
    send_req(we, size, uns, addr, wdata);
    get_rsp(tag, hold);
  endtask

  // ---------------- reference model for random phase ----------------
  logic [XLEN-1:0] ref_w[8];

  function automatic logic [XLEN-1:0] model_load(input logic [XLEN-1:0] w, input logic [1:0] lo,
                                                 input logic [1:0] size, input logic uns);
    logic [7:0] b;
    logic [15:0] h;
    b = 8'(w >> (8 * lo));
    h = 16'(w >> (8 * lo));
    if (size == SZ_BYTE) return uns ? {24'd0, b} : {{24{b[7]}}, b};
    if (size == SZ_HALF) return uns ? {16'd0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  function automatic logic [XLEN-1:0] model_store(input logic [XLEN-1:0] w, input logic [1:0] lo,
                                                  input logic [1:0] size, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    r = w;
    if (size == SZ_BYTE) r[8*lo +: 8] = d[7:0];
    else if (size == SZ_HALF) r[8*lo +: 16] = d[15:0];
    else r = d;
    return r;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; sel = 1'b0; exp_lat = 1;
    t_valid = 0; t_we = 0; t_uns = 0; t_rready = 0; t_size = 0; t_addr = 0; t_wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_valid1", {32'd0, bus1.rsp_valid}, 33'd0);
    check("rst_valid3", {32'd0, bus3.rsp_valid}, 33'd0);
    check("rst_data1", {bus1.rsp_err, bus1.rsp_rdata}, 33'd0);
    check("rst_data3", {bus3.rsp_err, bus3.rsp_rdata}, 33'd0);
    check("rst_ready1", {32'd0, bus1.req_ready}, 33'd1);
    check("rst_ready3", {32'd0, bus3.req_ready}, 33'd1);
    check("rst_state3", 33'(dbg3), 33'(IDLE));
    rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      exp_lat = sel ? 3 : 1;

      // word store/load
      do_req("st_w10", 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
      do_req("ld_w10", 0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);

      // byte store and extension
      do_req("st_b13", 1, SZ_BYTE, 0, 32'h13, 32'hFFFFFF80, 32'h0, 0, 0);
      do_req("ld_sb13", 0, SZ_BYTE, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 0);
      do_req("ld_ub13", 0, SZ_BYTE, 1, 32'h13, 32'h0, 32'h00000080, 0, 0);
      do_req("ld_w10b", 0, SZ_WORD, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0, 0);

      // half store and extension
      do_req("st_w20", 1, SZ_WORD, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0);
      do_req("st_h22", 1, SZ_HALF, 0, 32'h22, 32'h00001234, 32'h0, 0, 0);
      do_req("ld_w20", 0, SZ_WORD, 0, 32'h20, 32'h0, 32'h1234F00D, 0, 0);
      do_req("ld_sh22", 0, SZ_HALF, 0, 32'h22, 32'h0, 32'h00001234, 0, 0);
      do_req("st_h20", 1, SZ_HALF, 0, 32'h20, 32'hABCD8001, 32'h0, 0, 0);
      do_req("ld_sh20", 0, SZ_HALF, 0, 32'h20, 32'h0, 32'hFFFF8001, 0, 0);
      do_req("ld_uh20", 0, SZ_HALF, 1, 32'h20, 32'h0, 32'h00008001, 0, 0);
      do_req("ld_sb21", 0, SZ_BYTE, 0, 32'h21, 32'h0, 32'hFFFFFF80, 0, 0);

      // back-pressure on the response
      do_req("hold", 0, SZ_WORD, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0, 5);

      // index wrap: word DEPTH and a high address both alias word 0
      do_req("st_alias", 1, SZ_WORD, 0, 32'(4 * DEPTH), 32'h55AA55AA, 32'h0, 0, 0);
      do_req("ld_w0", 0, SZ_WORD, 0, 32'h0, 32'h0, 32'h55AA55AA, 0, 0);
      do_req("ld_ub1", 0, SZ_BYTE, 1, 32'h1, 32'h0, 32'h00000055, 0, 0);
      do_req("ld_hi", 0, SZ_WORD, 0, 32'hFFFFFF00, 32'h0, 32'h55AA55AA, 0, 0);

      // reset while a load is pending: response dropped
      send_req(0, SZ_WORD, 0, 32'h10, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstmid_valid", {32'd0, w_rsp_valid}, 33'd0);
      check("rstmid_state", 33'(w_dbg), 33'(IDLE));
      @(negedge clk);
      rst = 1'b0;
      // reset after a store was accepted: the write stays
      send_req(1, SZ_WORD, 0, 32'h30, 32'h12345678);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstst_valid", {32'd0, w_rsp_valid}, 33'd0);
      @(negedge clk);
      rst = 1'b0;
      do_req("ld_w30", 0, SZ_WORD, 0, 32'h30, 32'h0, 32'h12345678, 0, 0);

      // random phase against a word model at words 40..47
      for (int i = 0; i < 8; i++) begin
        ref_w[i] = $urandom;
        do_req("rnd_init", 1, SZ_WORD, 0, 32'(32'hA0 + 4 * i), ref_w[i], 32'h0, 0, 0);
      end
      for (int k = 0; k < 24; k++) begin
        int idx;
        logic [1:0] sz, lo;
        logic uns, we;
        logic [XLEN-1:0] d;
        idx = $urandom_range(0, 7);
        sz  = 2'($urandom_range(0, 2));
        lo  = (sz == SZ_BYTE) ? 2'($urandom_range(0, 3)) :
              (sz == SZ_HALF) ? 2'(2 * $urandom_range(0, 1)) : 2'd0;
        uns = 1'($urandom_range(0, 1));
        we  = 1'($urandom_range(0, 1));
        d   = $urandom;
        if (we) begin
          ref_w[idx] = model_store(ref_w[idx], lo, sz, d);
          do_req("rnd_st", 1, sz, uns, 32'(32'hA0 + 4 * idx + lo), d, 32'h0, 0, 0);
        end else begin
          do_req("rnd_ld", 0, sz, uns, 32'(32'hA0 + 4 * idx + lo), d,
                 model_load(ref_w[idx], lo, sz, uns), 0, 0);
        end
      end

      // misaligned accesses
`ifdef DMEM_MISALIGN_CHK_EN
      do_req("mis_st", 1, SZ_WORD, 0, 32'h11, 32'hA5A5A5A5, 32'h0, 1, 0);
      do_req("mis_rb", 0, SZ_WORD, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0, 0);
      do_req("mis_ldh", 0, SZ_HALF, 0, 32'h13, 32'h0, 32'h0, 1, 0);
      do_req("mis_sz3", 0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 0);
`else
      do_req("mis_st", 1, SZ_WORD, 0, 32'h11, 32'hA5A5A5A5, 32'h0, 0, 0);
      do_req("mis_rb", 0, SZ_WORD, 0, 32'h10, 32'h0, 32'hA5A5A5A5, 0, 0);
      do_req("mis_ldh", 0, SZ_HALF, 0, 32'h13, 32'h0, 32'hFFFFA5A5, 0, 0);
      do_req("mis_sz3", 0, 2'd3, 0, 32'h11, 32'h0, 32'hA5A5A5A5, 0, 0);
`endif
    end

    check("sb_empty", 33'(exp_q.size()), 33'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
